// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p fault-handling slice.
//   fault_mgr_state_e : replay/escalation FSM states of cv32e40p_fault_manager
package cv32e40p_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReplayReq,
    StReplayWait,
    StPermanent
  } fault_mgr_state_e;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : add one (ignored at the all-ones ceiling)
//   clr_i      : zero the counter; wins over inc_i
//   cnt_o      : current count
module cv32e40p_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_fault_manager.sv
// Collects TMR voter fault flags from the hardened EX units, keeps per-unit
// saturating fault counts and sticky status, asks the controller to replay the
// faulting instruction and escalates to a permanent fault after MAX_RETRY
// failed replays.
//   fault_i/fault_valid_i : per-unit voter flags, qualified by EX valid
//   instr_retire_i        : in-flight instruction completed cleanly
//   replay_req_o/ack_i    : replay handshake with the controller
//   permanent_fault_o     : unrecoverable fault, released only by clear_i
//   fault_irq_o           : sticky, some counter reached IRQ_THRESHOLD
//   status_o              : sticky per-unit fault-seen bits
//   rd_idx_i/rd_cnt_o     : combinational counter read port
//   clear_i               : clears counters, status, irq and PERMANENT
module cv32e40p_fault_manager
  import cv32e40p_pkg::*;
#(
  parameter int unsigned NUM_UNITS     = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned MAX_RETRY     = 2,
  parameter int unsigned IRQ_THRESHOLD = 16,
  localparam int unsigned RdW          = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] fault_i,
  input  logic                 fault_valid_i,
  input  logic                 instr_retire_i,
  output logic                 replay_req_o,
  input  logic                 replay_ack_i,
  output logic                 permanent_fault_o,
  output logic                 fault_irq_o,
  output logic [NUM_UNITS-1:0] status_o,
  input  logic [RdW-1:0]       rd_idx_i,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  input  logic                 clear_i
);

  localparam longint unsigned FAULT_CNT_MAX = (64'd1 << CNT_WIDTH) - 64'd1;
  // A threshold above the counter ceiling can never be reached.
  localparam bit IrqReachable = (64'(IRQ_THRESHOLD) <= FAULT_CNT_MAX);
  localparam logic [CNT_WIDTH-1:0] IrqLevel = CNT_WIDTH'(IRQ_THRESHOLD);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  logic [NUM_UNITS-1:0] fault_inc;
  logic                 fault_ev;
  logic [CNT_WIDTH-1:0] cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] at_thresh;
  logic [NUM_UNITS-1:0] status_q;
  logic                 irq_q;
  fault_mgr_state_e     state_q;
  logic [RetryW-1:0]    retry_cnt_q;

  assign fault_inc = fault_i & {NUM_UNITS{fault_valid_i}};
  assign fault_ev  = |fault_inc;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_cnt
    cv32e40p_sat_counter #(
      .WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc_i(fault_inc[k]),
      .clr_i(clear_i),
      .cnt_o(cnt[k])
    );
  end

  always_comb begin
    at_thresh = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      at_thresh[k] = IrqReachable && (cnt[k] >= IrqLevel);
    end
  end

  // Out-of-range indices match no unit and read as zero.
  always_comb begin
    rd_cnt_o = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (rd_idx_i == RdW'(k)) begin
        rd_cnt_o = cnt[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else if (clear_i) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_q | fault_inc;
      irq_q    <= irq_q | (|at_thresh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      retry_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fault_ev) begin
            state_q     <= StReplayReq;
            retry_cnt_q <= RetryW'(1);
          end
        end
        // Faults while the request is pending are counted only.
        StReplayReq: begin
          if (replay_ack_i) begin
            state_q <= StReplayWait;
          end
        end
        // A fault beats a simultaneous retire.
        StReplayWait: begin
          if (fault_ev) begin
            if (retry_cnt_q == RetryMax) begin
              state_q <= StPermanent;
            end else begin
              state_q     <= StReplayReq;
              retry_cnt_q <= retry_cnt_q + RetryW'(1);
            end
          end else if (instr_retire_i) begin
            state_q     <= StIdle;
            retry_cnt_q <= '0;
          end
        end
        StPermanent: begin
          if (clear_i) begin
            state_q     <= StIdle;
            retry_cnt_q <= '0;
          end
        end
        default: begin
          state_q     <= StIdle;
          retry_cnt_q <= '0;
        end
      endcase
    end
  end

  assign replay_req_o      = (state_q == StReplayReq);
  assign permanent_fault_o = (state_q == StPermanent);
  assign fault_irq_o       = irq_q;
  assign status_o          = status_q;

endmodule

// File: tb/tb_cv32e40p_fault_manager.sv
module tb_cv32e40p_fault_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] fault_i = '0;
  logic       fault_valid_i = 1'b0;
  logic       instr_retire_i = 1'b0;
  logic       replay_ack_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [1:0] rd_idx_i = '0;
  logic       replay_req_o, permanent_fault_o, fault_irq_o;
  logic [3:0] status_o;
  logic [7:0] rd_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cv32e40p_fault_manager dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fault_i          (fault_i),
    .fault_valid_i    (fault_valid_i),
    .instr_retire_i   (instr_retire_i),
    .replay_req_o     (replay_req_o),
    .replay_ack_i     (replay_ack_i),
    .permanent_fault_o(permanent_fault_o),
    .fault_irq_o      (fault_irq_o),
    .status_o         (status_o),
    .rd_idx_i         (rd_idx_i),
    .rd_cnt_o         (rd_cnt_o),
    .clear_i          (clear_i)
  );

  typedef struct {
    logic [3:0] fault;
    logic       valid;
    logic       retire;
    logic       ack;
    logic       clr;
    logic [1:0] idx;
    logic       exp_req;
    logic       exp_perm;
    logic       exp_irq;
    logic [3:0] exp_status;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] f, logic v, logic rt, logic ak, logic cl,
                              logic [1:0] ix, logic er, logic ep, logic ei,
                              logic [3:0] es, logic [7:0] ec);
    vec_t r;
    r.fault = f; r.valid = v; r.retire = rt; r.ack = ak; r.clr = cl; r.idx = ix;
    r.exp_req = er; r.exp_perm = ep; r.exp_irq = ei; r.exp_status = es; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] f, input logic v, input logic rt, input logic ak,
                       input logic cl, input logic [1:0] ix);
    fault_i = f; fault_valid_i = v; instr_retire_i = rt; replay_ack_i = ak;
    clear_i = cl; rd_idx_i = ix;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic er, input logic ep, input logic ei,
                           input logic [3:0] es, input logic [7:0] ec);
    chk({tag, " replay_req"}, 32'(replay_req_o), 32'(er));
    chk({tag, " permanent"}, 32'(permanent_fault_o), 32'(ep));
    chk({tag, " irq"}, 32'(fault_irq_o), 32'(ei));
    chk({tag, " status"}, 32'(status_o), 32'(es));
    chk({tag, " rd_cnt"}, 32'(rd_cnt_o), 32'(ec));
  endtask

  initial begin
    // Basic replay: fault, request held 3 cycles, ack, retire.
    vecs.push_back(mk(4'h1, 1, 0, 0, 0, 0, 1, 0, 0, 4'h1, 1));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h1, 1));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 4'h1, 1));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h1, 1));
    vecs.push_back(mk(4'h0, 0, 1, 0, 0, 0, 0, 0, 0, 4'h1, 1));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h1, 1));
    // Flags without valid are ignored.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(4'h2, 0, 0, 0, 0, 1, 0, 0, 0, 4'h1, 0));
    // Escalation: idle fault+retire replays, fault beats retire, fault in REQ only counts.
    vecs.push_back(mk(4'h1, 1, 1, 0, 0, 0, 1, 0, 0, 4'h1, 2));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h1, 2));
    vecs.push_back(mk(4'h1, 1, 1, 0, 0, 0, 1, 0, 0, 4'h1, 3));
    vecs.push_back(mk(4'h2, 1, 0, 0, 0, 0, 1, 0, 0, 4'h3, 3));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h3, 3));
    vecs.push_back(mk(4'h4, 1, 0, 0, 0, 0, 0, 1, 0, 4'h7, 3));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h7, 3));
    vecs.push_back(mk(4'h1, 1, 0, 0, 0, 0, 0, 1, 0, 4'h7, 4));
    vecs.push_back(mk(4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 4'h0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0));
    // Clear during a pending request keeps the request.
    vecs.push_back(mk(4'h8, 1, 0, 0, 0, 3, 1, 0, 0, 4'h8, 1));
    vecs.push_back(mk(4'h0, 0, 0, 0, 1, 3, 1, 0, 0, 4'h0, 0));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 3, 0, 0, 0, 4'h0, 0));
    vecs.push_back(mk(4'h0, 0, 1, 0, 0, 3, 0, 0, 0, 4'h0, 0));
    // Two units counting together up to the irq threshold.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(4'h9, 1, 0, 0, 0, 3, 1, 0, 0, 4'h9, 8'(i + 1)));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 3, 1, 0, 1, 4'h9, 16));
    vecs.push_back(mk(4'h0, 0, 0, 0, 0, 0, 1, 0, 1, 4'h9, 16));
    vecs.push_back(mk(4'h0, 0, 0, 1, 0, 0, 0, 0, 1, 4'h9, 16));
    vecs.push_back(mk(4'h0, 0, 1, 0, 0, 0, 0, 0, 1, 4'h9, 16));

    // Reset state.
    #12;
    check_all("reset", 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].fault, vecs[i].valid, vecs[i].retire, vecs[i].ack, vecs[i].clr,
            vecs[i].idx);
      cycle();
      check_all($sformatf("row%0d", i), vecs[i].exp_req, vecs[i].exp_perm, vecs[i].exp_irq,
                vecs[i].exp_status, vecs[i].exp_cnt);
    end

    // Saturation at the 8-bit ceiling.
    drive(4'h0, 0, 0, 0, 1, 2);
    cycle();
    check_all("sat_clr", 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 260; i++) begin
      drive(4'h4, 1, 0, 0, 0, 2);
      cycle();
      if (i == 254) chk("sat_reach", 32'(rd_cnt_o), 32'd255);
    end
    check_all("sat_hold", 1, 0, 1, 4'h4, 255);
    // Clear beats a same-cycle fault.
    drive(4'h4, 1, 0, 0, 1, 2);
    cycle();
    check_all("clr_vs_fault", 1, 0, 0, 4'h0, 0);
    drive(4'h0, 0, 0, 1, 0, 2);
    cycle();
    drive(4'h0, 0, 1, 0, 0, 2);
    cycle();
    chk("sat_idle req", 32'(replay_req_o), 32'd0);

    // Asynchronous reset mid-request.
    drive(4'h2, 1, 0, 0, 0, 1);
    cycle();
    chk("pre_rst req", 32'(replay_req_o), 32'd1);
    drive(4'h0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 4'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_all($sformatf("post_rst%0d", i), 0, 0, 0, 4'h0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
